// File: rtl/mem_stage.sv
// mem_stage: byte-serial load/store stage between EX/MEM and WB with upstream stall
module mem_stage #(
   parameter int CMD_W  = 6,
   parameter int ADDR_W = 32
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              valid_in,
   input  logic [CMD_W-1:0]  cmdtype_in,
   input  logic [4:0]        rsd_addr_in,
   input  logic [31:0]       rsd_data_in,
   input  logic              write_rsd_in,
   input  logic [31:0]       store_data_in,
   output logic              stall_out,
   output logic              mem_req,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_ack,
   output logic              valid_out,
   output logic [4:0]        rsd_addr_out,
   output logic [31:0]       rsd_data_out,
   output logic              write_rsd_out
);
   // Memory command encodings; loads occupy LB..LHU and stores SB..SW contiguously.
   localparam logic [CMD_W-1:0] CMD_LB  = CMD_W'(10);
   localparam logic [CMD_W-1:0] CMD_LH  = CMD_W'(11);
   localparam logic [CMD_W-1:0] CMD_LW  = CMD_W'(12);
   localparam logic [CMD_W-1:0] CMD_LBU = CMD_W'(13);
   localparam logic [CMD_W-1:0] CMD_LHU = CMD_W'(14);
   localparam logic [CMD_W-1:0] CMD_SB  = CMD_W'(15);
   localparam logic [CMD_W-1:0] CMD_SH  = CMD_W'(16);
   localparam logic [CMD_W-1:0] CMD_SW  = CMD_W'(17);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t              state_q, state_d;
   logic [CMD_W-1:0]    cmd_q, cmd_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [31:0]         sdata_q, sdata_d;
   logic [31:0]         asm_q, asm_d;
   logic [4:0]          rsd_q, rsd_d;
   logic                wen_q, wen_d;
   logic [1:0]          idx_q, idx_d;
   logic                valid_q, valid_d;
   logic [4:0]          out_rd_q, out_rd_d;
   logic [31:0]         out_data_q, out_data_d;
   logic                out_wr_q, out_wr_d;
   logic                in_mem, is_store, in_acc;
   logic [1:0]          last_idx;
   logic [31:0]         word, ext;

   assign in_mem   = cmdtype_in >= CMD_LB && cmdtype_in <= CMD_SW;
   assign is_store = cmd_q >= CMD_SB;
   assign in_acc   = state_q == ACCESS;
   assign last_idx = (cmd_q == CMD_LB || cmd_q == CMD_LBU || cmd_q == CMD_SB) ? 2'd0 :
                     (cmd_q == CMD_LH || cmd_q == CMD_LHU || cmd_q == CMD_SH) ? 2'd1 : 2'd3;

   assign stall_out     = in_acc || (state_q == IDLE && valid_in && in_mem);
   assign mem_req       = in_acc;
   assign mem_wr        = in_acc && is_store;
   assign mem_addr      = in_acc ? base_q + ADDR_W'(idx_q) : '0;
   assign mem_wdata     = mem_wr ? sdata_q[{idx_q, 3'b000} +: 8] : '0;
   assign valid_out     = valid_q;
   assign rsd_addr_out  = out_rd_q;
   assign rsd_data_out  = out_data_q;
   assign write_rsd_out = out_wr_q;

   // Merge the byte arriving now into the assembled word and extend it for the load type.
   always_comb begin
      word = asm_q;
      word[{idx_q, 3'b000} +: 8] = mem_rdata;
      ext = cmd_q == CMD_LB  ? {{24{word[7]}}, word[7:0]} :
            cmd_q == CMD_LH  ? {{16{word[15]}}, word[15:0]} :
            cmd_q == CMD_LBU ? {24'd0, word[7:0]} :
            cmd_q == CMD_LHU ? {16'd0, word[15:0]} : word;
   end

   // Next-state: accept records in IDLE, walk bytes in ACCESS, publish result into DONE.
   always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      base_d     = base_q;
      sdata_d    = sdata_q;
      asm_d      = asm_q;
      rsd_d      = rsd_q;
      wen_d      = wen_q;
      idx_d      = idx_q;
      valid_d    = 1'b0;
      out_rd_d   = out_rd_q;
      out_data_d = out_data_q;
      out_wr_d   = out_wr_q;
      unique case (state_q)
         IDLE: begin
            if (valid_in && in_mem) begin
               cmd_d   = cmdtype_in;
               base_d  = ADDR_W'(rsd_data_in);
               sdata_d = store_data_in;
               rsd_d   = rsd_addr_in;
               wen_d   = write_rsd_in;
               idx_d   = 2'd0;
               asm_d   = 32'd0;
               state_d = ACCESS;
            end else if (valid_in) begin
               valid_d    = 1'b1;
               out_rd_d   = rsd_addr_in;
               out_data_d = rsd_data_in;
               out_wr_d   = write_rsd_in && rsd_addr_in != 5'd0;
            end
         end
         ACCESS: begin
            if (mem_ack) begin
               asm_d = is_store ? asm_q : word;
               idx_d = idx_q + 2'd1;
               if (idx_q == last_idx) begin
                  state_d    = DONE;
                  valid_d    = 1'b1;
                  out_rd_d   = rsd_q;
                  out_data_d = is_store ? 32'd0 : ext;
                  out_wr_d   = !is_store && wen_q && rsd_q != 5'd0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous active-low reset clearing everything.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q    <= IDLE;
         cmd_q      <= '0;
         base_q     <= '0;
         sdata_q    <= '0;
         asm_q      <= '0;
         rsd_q      <= '0;
         wen_q      <= 1'b0;
         idx_q      <= '0;
         valid_q    <= 1'b0;
         out_rd_q   <= '0;
         out_data_q <= '0;
         out_wr_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         base_q     <= base_d;
         sdata_q    <= sdata_d;
         asm_q      <= asm_d;
         rsd_q      <= rsd_d;
         wen_q      <= wen_d;
         idx_q      <= idx_d;
         valid_q    <= valid_d;
         out_rd_q   <= out_rd_d;
         out_data_q <= out_data_d;
         out_wr_q   <= out_wr_d;
      end
   end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized scoreboard bench for mem_stage with a byte memory responder
module tb_mem_stage;
   localparam logic [5:0] ADDI = 6'd2, ADD = 6'd1, NOP = 6'd0;
   localparam logic [5:0] LB = 6'd10, LH = 6'd11, LW = 6'd12, LBU = 6'd13, LHU = 6'd14;
   localparam logic [5:0] SB = 6'd15, SH = 6'd16, SW = 6'd17;

   logic        clk = 1'b0;
   logic        rst_in = 1'b0;
   logic        valid_in = 1'b0;
   logic [5:0]  cmdtype_in = '0;
   logic [4:0]  rsd_addr_in = '0;
   logic [31:0] rsd_data_in = '0;
   logic        write_rsd_in = 1'b0;
   logic [31:0] store_data_in = '0;
   logic        stall_out, mem_req, mem_wr, mem_ack, valid_out, write_rsd_out;
   logic [31:0] mem_addr, rsd_data_out;
   logic [7:0]  mem_wdata, mem_rdata;
   logic [4:0]  rsd_addr_out;

   mem_stage #(.CMD_W(6), .ADDR_W(32)) dut (
      .clk_in(clk), .rst_in(rst_in), .valid_in(valid_in), .cmdtype_in(cmdtype_in),
      .rsd_addr_in(rsd_addr_in), .rsd_data_in(rsd_data_in), .write_rsd_in(write_rsd_in),
      .store_data_in(store_data_in), .stall_out(stall_out), .mem_req(mem_req),
      .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack), .valid_out(valid_out), .rsd_addr_out(rsd_addr_out),
      .rsd_data_out(rsd_data_out), .write_rsd_out(write_rsd_out)
   );

   always #5 clk = ~clk;

   typedef struct {logic [4:0] rd; logic [31:0] data; logic wr;} wb_t;
   typedef struct {logic [31:0] addr; logic wr; logic [7:0] wdata;} bus_t;
   wb_t  exp_q[$];
   bus_t bus_q[$];
   logic [7:0] ref_mem [logic [31:0]];
   logic [7:0] bus_mem [logic [31:0]];
   int total = 0, bad = 0;
   int dmin = 0, dmax = 0;
   logic resp_en = 1'b1;

   function automatic logic [7:0] dflt(input logic [31:0] a);
      return a[7:0] ^ 8'h5A;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int nbytes(input logic [5:0] c);
      return (c == LB || c == LBU || c == SB) ? 1 : (c == LH || c == LHU || c == SH) ? 2 : 4;
   endfunction

   // Reference model: predict bus traffic and the writeback record from the command's meaning.
   task automatic predict(input logic [5:0] c, input logic [31:0] d, input logic [4:0] rd,
                          input logic w, input logic [31:0] sd);
      logic [31:0] val, a;
      logic [7:0]  b;
      int n;
      if (c >= SB && c <= SW) begin
         n = nbytes(c);
         for (int k = 0; k < n; k++) begin
            a = d + k;
            b = 8'((sd >> (8 * k)) & 32'hFF);
            bus_q.push_back('{a, 1'b1, b});
            ref_mem[a] = b;
         end
         exp_q.push_back('{rd, 32'd0, 1'b0});
      end else if (c >= LB && c <= LHU) begin
         n = nbytes(c);
         val = 0;
         for (int k = 0; k < n; k++) begin
            a = d + k;
            b = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
            bus_q.push_back('{a, 1'b0, 8'd0});
            val = val + (32'(b) << (8 * k));
         end
         if (c == LB && val >= 128) val = val - 256;
         if (c == LH && val >= 32768) val = val - 65536;
         exp_q.push_back('{rd, val, w && rd != 0});
      end else
         exp_q.push_back('{rd, d, w && rd != 0});
   endtask

   // Drive one record (called at a negedge) and hold it until the stage stops stalling.
   task automatic issue(input logic [5:0] c, input logic [31:0] d, input logic [4:0] rd,
                        input logic w, input logic [31:0] sd, output int sc);
      logic st;
      predict(c, d, rd, w, sd);
      valid_in = 1'b1; cmdtype_in = c; rsd_data_in = d; rsd_addr_in = rd;
      write_rsd_in = w; store_data_in = sd;
      sc = 0;
      for (int t = 0; ; t++) begin
         #1 st = stall_out;
         @(posedge clk);
         if (!st) break;
         sc++;
         if (t > 60) begin
            $display("FAIL stall_timeout got=%0d expected=<60", t);
            $fatal(1, "stall never released");
         end
      end
      @(negedge clk);
      valid_in = 1'b0;
   endtask

   // Memory responder: checks each request against the expected bus queue, acks after a delay.
   initial begin
      bus_t t;
      int n;
      mem_ack = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (resp_en) begin
            mem_ack = 1'b0;
            if (rst_in && mem_req) begin
               if (bus_q.size() == 0) chk("bus_extra", 32'd1, 32'd0);
               else begin
                  t = bus_q.pop_front();
                  chk("bus_addr", mem_addr, t.addr);
                  chk("bus_wr", 32'(mem_wr), 32'(t.wr));
                  if (t.wr) chk("bus_wdata", 32'(mem_wdata), 32'(t.wdata));
                  n = $urandom_range(dmax, dmin);
                  repeat (n) begin
                     @(negedge clk);
                     chk("bus_hold_addr", mem_addr, t.addr);
                     chk("bus_hold_req", 32'(mem_req), 32'd1);
                  end
                  mem_ack = 1'b1;
                  if (mem_wr) bus_mem[mem_addr] = mem_wdata;
                  mem_rdata = bus_mem.exists(mem_addr) ? bus_mem[mem_addr] : dflt(mem_addr);
               end
            end
         end
      end
   end

   // Writeback monitor: every valid_out pulse must match the oldest predicted record.
   initial begin
      wb_t e;
      forever begin
         @(negedge clk);
         if (rst_in && valid_out) begin
            if (exp_q.size() == 0) chk("wb_extra", 32'd1, 32'd0);
            else begin
               e = exp_q.pop_front();
               chk("wb_rd", 32'(rsd_addr_out), 32'(e.rd));
               chk("wb_data", rsd_data_out, e.data);
               chk("wb_wr", 32'(write_rsd_out), 32'(e.wr));
            end
         end
      end
   end

   initial begin
      int sc;
      logic [5:0] cmds[11] = '{NOP, ADD, ADDI, LB, LH, LW, LBU, LHU, SB, SH, SW};
      logic [5:0] c;
      logic [31:0] a;
      repeat (3) @(negedge clk);
      chk("rst_req", 32'(mem_req), 0);
      chk("rst_stall", 32'(stall_out), 0);
      chk("rst_valid", 32'(valid_out), 0);
      chk("rst_data", rsd_data_out, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_rd", 32'(rsd_addr_out), 0);
      rst_in = 1'b1;
      @(negedge clk);

      issue(ADD, 32'h1234, 5'd5, 1'b1, 32'd0, sc);
      chk("add_stall", sc, 0);

      {ref_mem[32'h100], ref_mem[32'h101], ref_mem[32'h102], ref_mem[32'h103]} = 32'h78563412;
      {bus_mem[32'h100], bus_mem[32'h101], bus_mem[32'h102], bus_mem[32'h103]} = 32'h78563412;
      issue(LW, 32'h100, 5'd9, 1'b1, 32'd0, sc);
      chk("lw_stall", sc, 5);

      ref_mem[32'h80] = 8'h80;
      bus_mem[32'h80] = 8'h80;
      dmin = 3; dmax = 3;
      issue(LB, 32'h80, 5'd3, 1'b1, 32'd0, sc);
      issue(LBU, 32'h80, 5'd4, 1'b1, 32'd0, sc);
      dmin = 0; dmax = 0;
      issue(SH, 32'h2001, 5'd6, 1'b0, 32'hAABBCCDD, sc);
      issue(LH, 32'h2001, 5'd0, 1'b1, 32'd0, sc);
      issue(LW, 32'hFFFF_FFFE, 5'd12, 1'b1, 32'd0, sc);

      dmax = 3;
      for (int i = 0; i < 150; i++) begin
         c = cmds[$urandom_range(10, 0)];
         a = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF8 + $urandom_range(7, 0)
                                         : 32'h2000 + $urandom_range(31, 0);
         if (c < LB) issue(c, $urandom, 5'($urandom), 1'($urandom), $urandom, sc);
         else issue(c, a, 5'($urandom), c < SB, $urandom, sc);
      end
      dmax = 0;
      repeat (3) @(negedge clk);

      resp_en = 1'b0;
      mem_ack = 1'b0;
      valid_in = 1'b1; cmdtype_in = LW; rsd_data_in = 32'h3000; rsd_addr_in = 5'd7;
      write_rsd_in = 1'b1;
      @(negedge clk);
      valid_in = 1'b0;
      chk("rst_mid_req_on", 32'(mem_req), 1);
      mem_ack = 1'b1; mem_rdata = 8'h11;
      @(negedge clk);
      mem_ack = 1'b1; mem_rdata = 8'h22;
      @(negedge clk);
      mem_ack = 1'b0;
      rst_in = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_mid_req", 32'(mem_req), 0);
      chk("rst_mid_stall", 32'(stall_out), 0);
      chk("rst_mid_valid", 32'(valid_out), 0);
      chk("rst_mid_data", rsd_data_out, 0);
      @(negedge clk);
      rst_in = 1'b1;
      resp_en = 1'b1;
      issue(ADDI, 32'h0000_0042, 5'd8, 1'b1, 32'd0, sc);
      chk("addi_stall", sc, 0);

      repeat (10) @(negedge clk);
      chk("drain_wb", exp_q.size(), 0);
      chk("drain_bus", bus_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage that sits directly downstream of the execute stage, behind the EX/MEM boundary.
- Takes the execute result (destination register, data, write-enable, command type), performs LB/LH/LW/LBU/LHU/SB/SH/SW over a byte-wide request/acknowledge memory port, and hands a registered writeback record to the WB stage.
- Raises a stall request to the upstream pipeline while a multi-byte access is in progress.

Parameters:
- CMD_W, 6, width of the command-type field; must match the `Cmd_Typebus` width, with `Cmd*` encodings taken from define.v.
- ADDR_W, 32, byte-address width.

Ports:
- clk_in  in  1  clock; all state updates on the rising edge.
- rst_in  in  1  reset; synchronous, active-low (0 = reset).
- valid_in  in  1  EX/MEM record valid.
- cmdtype_in  in  CMD_W  command type.
- rsd_addr_in  in  5  destination register.
- rsd_data_in  in  32  execute result: value for ALU/LUI/AUIPC/JAL/JALR, effective address for loads and stores.
- write_rsd_in  in  1  destination write-enable from execute.
- store_data_in  in  32  rs2 value for stores.
- stall_out  out  1  upstream must hold its inputs stable.
- mem_req  out  1  byte request.
- mem_wr  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  8  write byte.
- mem_rdata  in  8  read byte; valid in the mem_ack cycle.
- mem_ack  in  1  one-cycle acknowledge of the current byte.
- valid_out  out  1  writeback record valid; one-cycle pulse.
- rsd_addr_out  out  5  writeback register.
- rsd_data_out  out  32  writeback data.
- write_rsd_out  out  1  writeback enable.

Behaviour:
- Reset (rst_in = 0 at an edge):
  - state goes to IDLE.
  - All outputs go to 0: stall_out, mem_req, mem_wr, mem_addr, mem_wdata, valid_out, rsd_addr_out, rsd_data_out, write_rsd_out.
  - Reset mid-access aborts the access; mem_req is low from the next cycle and no partial result is ever output.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - valid_in = 1 with a non-memory command: register the record, valid_out = 1 on the next cycle (latency 1), stay in IDLE, stall_out stays 0.
  - valid_in = 1 with a load or store: latch address, command, store data and rsd; set byte count N (1 for B/BU, 2 for H/HU, 4 for W) and byte index i = 0; go to ACCESS.
  - stall_out is combinational: 1 in IDLE when valid_in carries a load/store, 1 throughout ACCESS, 0 in DONE. Upstream therefore advances on the DONE cycle's edge.
- ACCESS:
  - mem_req = 1, mem_addr = base + i (wraps modulo 2^ADDR_W), mem_wr = 1 for stores, mem_wdata = store_data[8i+7:8i].
  - Address, write and write-data outputs stay stable until mem_ack.
  - On mem_ack: a load stores mem_rdata into byte i of the assembly register; i increments.
  - On the ack with i = N-1: mem_req drops on the next cycle and the FSM goes to DONE.
  - mem_ack while mem_req = 0 is ignored.
- DONE (1 cycle):
  - valid_out = 1 and rsd_addr_out = latched rsd.
  - Data is little-endian. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW uses all 32 bits.
  - Stores: write_rsd_out = 0, rsd_data_out = 0.
  - Next state is IDLE. A new valid_in is accepted in the cycle after DONE.
- x0 rule: write_rsd_out is forced to 0 whenever rsd_addr_out = 0.
- Minimum latency with zero-wait ack (ack in the first request cycle): LW accepted at cycle T gives requests in T+1..T+4 and valid_out at T+5; LB gives valid_out at T+2.
- valid_in = 0 in IDLE: valid_out = 0 next cycle; the other output fields are don't-care but are held.
- Unaligned addresses are legal, because access is bytewise.

Test Plan:
- ADD record: rsd = 5, data 0x0000_1234, write = 1 in IDLE → next cycle valid_out = 1, rsd_addr_out = 5, data 0x1234, write_rsd_out = 1, stall_out = 0 throughout.
- LW: addr 0x100, memory bytes 0x78, 0x56, 0x34, 0x12, ack every cycle → mem_addr sequence 0x100..0x103, stall_out high for 5 cycles, then rsd_data_out = 0x1234_5678.
- LB and LBU at a byte 0x80, ack delayed 3 cycles → LB returns 0xFFFF_FF80, LBU returns 0x0000_0080; mem_addr is held stable during the wait.
- SH: addr 0x2001, store_data 0xAABB_CCDD → writes 0xDD to 0x2001 and 0xCC to 0x2002; then valid_out = 1 with write_rsd_out = 0.
- LH with rsd = 0 → valid_out = 1 with write_rsd_out = 0; LW at 0xFFFF_FFFE → addresses 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0, 0x1.
- rst_in = 0 after the 2nd ack of an LW → next cycle mem_req = 0, stall_out = 0, valid_out = 0, state IDLE; a following ADDI completes normally.
